rd_data_checker: RTL and testbench

RD_DATA_CHECKER -- requirements
Module: rd_data_checker

---
 rtl/rd_data_checker_pkg.sv | 22 ++
 rtl/rd_data_checker_sat_cnt16.sv | 23 ++
 rtl/rd_data_checker.sv | 114 +++++++++++
 tb/tb_rd_data_checker.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/rd_data_checker_pkg.sv
// Shared constants, state encodings and types for the read-data burst checker.
package rd_data_checker_pkg;

  localparam int DQ_WIDTH = 16;
  localparam logic [DQ_WIDTH-1:0] PAT_STEP = 16'd2;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_DATA = 2'd1;
  localparam logic [1:0] ST_REPORT    = 2'd2;
  localparam logic [1:0] ST_TIMEOUT   = 2'd3;

  typedef struct packed {
    logic [DQ_WIDTH-1:0] expected;
    logic [DQ_WIDTH-1:0] received;
  } bad_word_t;

  // BURST_LEN encoding 00/01/10/11 -> 1/2/4/8 words
  function automatic int burst_words(input logic [1:0] enc);
    return 1 << enc;
  endfunction

endpackage

// File: rtl/rd_data_checker_sat_cnt16.sv
// 16-bit saturating event counter with synchronous clear.
module sat_cnt16
  import rd_data_checker_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clr,
  input  logic                i_inc,
  output logic [DQ_WIDTH-1:0] o_cnt
);

  logic [DQ_WIDTH-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr)
      cnt <= '0;
    else if (i_inc && cnt != '1)
      cnt <= cnt + DQ_WIDTH'(1);
  end

  assign o_cnt = cnt;

endmodule

// File: rtl/rd_data_checker.sv
// Checks each read burst against the 2,4,6.. pattern, with timeout and
// sticky error reporting plus pass/fail burst counters.
module rd_data_checker
  import rd_data_checker_pkg::*;
#(
  parameter logic [1:0] BURST_LEN   = 2'b00,
  parameter int         TIMEOUT_CYC = 1023
)(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_rd_req,
  input  logic                rd_data_valid,
  input  logic [DQ_WIDTH-1:0] rd_data,
  input  logic                i_clr,
  output logic                o_chk_done,
  output logic                o_err,
  output logic                o_timeout,
  output logic [15:0]         o_pass_cnt,
  output logic [15:0]         o_err_cnt,
  output logic [31:0]         o_first_bad
);

  localparam int         TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [3:0] LAST_IDX = 4'(burst_words(BURST_LEN) - 1);

  logic [1:0]          state;
  logic                req_q;
  logic [DQ_WIDTH-1:0] expected;
  logic [3:0]          word_cnt;
  logic [TW-1:0]       timer;
  logic                burst_bad;
  logic                captured;
  bad_word_t           first_bad;
  logic                in_wait, mismatch, stray, rep_pass, rep_fail, in_tmo;

  assign in_wait  = (state == ST_WAIT_DATA);
  assign in_tmo   = (state == ST_TIMEOUT);
  assign mismatch = in_wait && rd_data_valid && (rd_data != expected);
  assign stray    = rd_data_valid && !in_wait;
  assign rep_pass = (state == ST_REPORT) && !burst_bad;
  assign rep_fail = (state == ST_REPORT) && burst_bad;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      req_q     <= 1'b0;
      expected  <= '0;
      word_cnt  <= '0;
      timer     <= '0;
      burst_bad <= 1'b0;
    end else begin
      req_q <= i_rd_req;
      case (state)
        ST_IDLE: if (i_rd_req && !req_q) begin
          state     <= ST_WAIT_DATA;
          expected  <= PAT_STEP;
          word_cnt  <= '0;
          timer     <= '0;
          burst_bad <= 1'b0;
        end
        ST_WAIT_DATA: if (rd_data_valid) begin
          expected <= expected + PAT_STEP;
          word_cnt <= word_cnt + 4'd1;
          timer    <= '0;
          if (mismatch) burst_bad <= 1'b1;
          if (word_cnt == LAST_IDX) state <= ST_REPORT;
        end else begin
          timer <= timer + TW'(1);
          if (timer == TW'(TIMEOUT_CYC - 1)) state <= ST_TIMEOUT;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky flags; clear beats any same-cycle set.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      o_err     <= 1'b0;
      o_timeout <= 1'b0;
      first_bad <= '0;
      captured  <= 1'b0;
    end else begin
      if (stray || rep_fail || in_tmo) o_err <= 1'b1;
      if (in_tmo) o_timeout <= 1'b1;
      // expected field records the pattern value after this word's advance
      if (mismatch && !captured) begin
        first_bad.expected <= expected + PAT_STEP;
        first_bad.received <= rd_data;
        captured           <= 1'b1;
      end
    end
  end

  sat_cnt16 u_pass_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (i_clr),
    .i_inc (rep_pass),
    .o_cnt (o_pass_cnt)
  );

  sat_cnt16 u_err_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (i_clr),
    .i_inc (rep_fail || in_tmo),
    .o_cnt (o_err_cnt)
  );

  assign o_chk_done  = (state == ST_REPORT) || in_tmo;
  assign o_first_bad = first_bad;

endmodule

// File: tb/tb_rd_data_checker.sv
// Directed bench: three checker instances (4-, 2- and 8-word bursts) share stimulus.
module tb_rd_data_checker;

  logic        i_clk = 1'b0;
  logic        i_rst, i_rd_req, rd_data_valid, i_clr;
  logic [15:0] rd_data;

  logic [2:0]       done, err, tmo;
  logic [2:0][15:0] pcnt, ecnt;
  logic [2:0][31:0] fbad;

  int n_chk = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  // index 0: 4-word, 1: 2-word, 2: 8-word
  rd_data_checker #(.BURST_LEN(2'b10), .TIMEOUT_CYC(16)) u_b4 (
    .i_clk(i_clk), .i_rst(i_rst), .i_rd_req(i_rd_req), .rd_data_valid(rd_data_valid),
    .rd_data(rd_data), .i_clr(i_clr), .o_chk_done(done[0]), .o_err(err[0]),
    .o_timeout(tmo[0]), .o_pass_cnt(pcnt[0]), .o_err_cnt(ecnt[0]), .o_first_bad(fbad[0]));

  rd_data_checker #(.BURST_LEN(2'b01), .TIMEOUT_CYC(16)) u_b2 (
    .i_clk(i_clk), .i_rst(i_rst), .i_rd_req(i_rd_req), .rd_data_valid(rd_data_valid),
    .rd_data(rd_data), .i_clr(i_clr), .o_chk_done(done[1]), .o_err(err[1]),
    .o_timeout(tmo[1]), .o_pass_cnt(pcnt[1]), .o_err_cnt(ecnt[1]), .o_first_bad(fbad[1]));

  rd_data_checker #(.BURST_LEN(2'b11), .TIMEOUT_CYC(16)) u_b8 (
    .i_clk(i_clk), .i_rst(i_rst), .i_rd_req(i_rd_req), .rd_data_valid(rd_data_valid),
    .rd_data(rd_data), .i_clr(i_clr), .o_chk_done(done[2]), .o_err(err[2]),
    .o_timeout(tmo[2]), .o_pass_cnt(pcnt[2]), .o_err_cnt(ecnt[2]), .o_first_bad(fbad[2]));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp_v);
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_rd_req = 1'b0; rd_data_valid = 1'b0; rd_data = '0; i_clr = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic rq();
    i_rd_req = 1'b1;
    @(negedge i_clk);
    i_rd_req = 1'b0;
  endtask

  task automatic word(input logic [15:0] d);
    rd_data_valid = 1'b1;
    rd_data       = d;
    @(negedge i_clk);
    rd_data_valid = 1'b0;
  endtask

  task automatic burst(input int n);
    for (int k = 1; k <= n; k++) word(16'(2 * k));
  endtask

  initial begin
    i_rst = 1'b1; i_rd_req = 1'b0; rd_data_valid = 1'b0; rd_data = '0; i_clr = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("rst_done", {29'd0, done}, 32'd0);
    chk("rst_err",  {29'd0, err | tmo}, 32'd0);
    chk("rst_pcnt", {16'd0, pcnt[0]}, 32'd0);
    chk("rst_fbad", fbad[0], 32'd0);
    i_rst = 1'b0;

    // 4-word passing burst, done exactly one cycle after the last word
    rq();
    word(16'd2); word(16'd4); word(16'd6);
    chk("b4_done_early", {31'd0, done[0]}, 32'd0);
    word(16'd8);
    chk("b4_done", {31'd0, done[0]}, 32'd1);
    @(negedge i_clk);
    chk("b4_done_pulse", {31'd0, done[0]}, 32'd0);
    chk("b4_pcnt", {16'd0, pcnt[0]}, 32'd1);
    chk("b4_err", {31'd0, err[0]}, 32'd0);

    // 2-word bursts with mismatches; first_bad sticks to the first one
    do_reset();
    rq();
    word(16'd2); word(16'd5);
    chk("b2_done", {31'd0, done[1]}, 32'd1);
    @(negedge i_clk);
    chk("b2_ecnt", {16'd0, ecnt[1]}, 32'd1);
    chk("b2_err", {31'd0, err[1]}, 32'd1);
    chk("b2_fbad", fbad[1], 32'h0006_0005);
    chk("b2_pcnt", {16'd0, pcnt[1]}, 32'd0);
    rq();
    word(16'd2); word(16'd3);
    @(negedge i_clk);
    chk("b2_fbad_keep", fbad[1], 32'h0006_0005);
    chk("b2_ecnt2", {16'd0, ecnt[1]}, 32'd2);

    // timeout: WAIT_DATA entered at first edge, TIMEOUT 16 cycles later
    do_reset();
    rq();
    repeat (15) @(negedge i_clk);
    chk("to_done_early", {31'd0, done[0]}, 32'd0);
    @(negedge i_clk);
    chk("to_done", {31'd0, done[0]}, 32'd1);
    @(negedge i_clk);
    chk("to_flag", {31'd0, tmo[0]}, 32'd1);
    chk("to_err", {31'd0, err[0]}, 32'd1);
    chk("to_ecnt", {16'd0, ecnt[0]}, 32'd1);
    chk("to_done_pulse", {31'd0, done[0]}, 32'd0);
    rq();
    burst(4);
    @(negedge i_clk);
    chk("to_then_pass", {16'd0, pcnt[0]}, 32'd1);

    // clear wipes flags and counters
    i_clr = 1'b1;
    @(negedge i_clk);
    i_clr = 1'b0;
    chk("clr_flags", {30'd0, err[0], tmo[0]}, 32'd0);
    chk("clr_cnts", {pcnt[0], ecnt[0]}, 32'd0);

    // stray word in IDLE: error only
    word(16'd2);
    chk("stray_err", {31'd0, err[0]}, 32'd1);
    chk("stray_cnts", {pcnt[0], ecnt[0]}, 32'd0);
    chk("stray_done", {31'd0, done[0]}, 32'd0);
    i_clr = 1'b1;
    @(negedge i_clk);
    i_clr = 1'b0;
    chk("stray_clr", {31'd0, err[0]}, 32'd0);

    // reset mid-burst on the 8-word checker, then a clean burst
    word(16'd2);
    rq();
    word(16'd2); word(16'd4);
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("mid_rst_flags", {29'd0, err[2], tmo[2], done[2]}, 32'd0);
    chk("mid_rst_cnts", {pcnt[2], ecnt[2]}, 32'd0);
    i_rst = 1'b0;
    rq();
    burst(8);
    chk("b8_done", {31'd0, done[2]}, 32'd1);
    @(negedge i_clk);
    chk("b8_pcnt", {16'd0, pcnt[2]}, 32'd1);
    chk("b8_err", {31'd0, err[2]}, 32'd0);

    // saturation, then clear coincident with a REPORT increment
    do_reset();
    force u_b4.u_pass_cnt.cnt = 16'hFFFE;
    @(negedge i_clk);
    release u_b4.u_pass_cnt.cnt;
    chk("sat_preset", {16'd0, pcnt[0]}, 32'h0000_FFFE);
    for (int b = 0; b < 3; b++) begin
      rq();
      burst(4);
      @(negedge i_clk);
      chk($sformatf("sat_%0d", b), {16'd0, pcnt[0]}, 32'h0000_FFFF);
    end
    rq();
    burst(4);
    i_clr = 1'b1;
    @(negedge i_clk);
    i_clr = 1'b0;
    chk("clr_vs_report", {16'd0, pcnt[0]}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
